// File: rtl/fb_bank_arbiter_pkg.sv
// Shared constants, FSM encoding and address helper for the double-buffered
// frame-buffer arbiter (80x60 RGB444, two banks in one BRAM).
package fb_pkg;

    localparam int c_img_cols    = 80;
    localparam int c_img_rows    = 60;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = 13;
    localparam int c_nb_buf      = 12;

    localparam logic [c_nb_img_pxls-1:0] c_img_pxls_a = c_nb_img_pxls'(c_img_pxls);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_DONE = 2'd1,
        S_RD_DONE = 2'd2,
        S_SWAP    = 2'd3
    } swap_state_e;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

    function automatic logic addr_in_range(input logic [c_nb_img_pxls-1:0] addr);
        return (addr < c_img_pxls_a);
    endfunction

endpackage

// File: rtl/fb_bank_arbiter_if.sv
// Requester, BRAM and bank-status signals of the frame-buffer arbiter.
// The arbiter uses the slave modport; the surrounding logic uses master.
interface fb_bank_arbiter_if import fb_pkg::*; ();

    logic                       freeze;
    logic                       wr_req;
    logic [c_nb_img_pxls-1:0]   wr_addr;
    logic [c_nb_buf-1:0]        wr_data;
    logic                       wr_ack;
    logic                       wr_frame_done;
    logic                       rd_req;
    logic [c_nb_img_pxls-1:0]   rd_addr;
    logic                       rd_ack;
    logic                       rd_valid;
    logic [c_nb_buf-1:0]        rd_data;
    logic                       rd_frame_done;
    logic                       mem_en;
    logic                       mem_we;
    logic [c_nb_img_pxls:0]     mem_addr;
    logic [c_nb_buf-1:0]        mem_wdata;
    logic [c_nb_buf-1:0]        mem_rdata;
    logic                       front_bank;
    logic                       swap;

    modport slave (
        input  freeze, wr_req, wr_addr, wr_data, wr_frame_done,
               rd_req, rd_addr, rd_frame_done, mem_rdata,
        output wr_ack, rd_ack, rd_valid, rd_data,
               mem_en, mem_we, mem_addr, mem_wdata, front_bank, swap
    );

    modport master (
        output freeze, wr_req, wr_addr, wr_data, wr_frame_done,
               rd_req, rd_addr, rd_frame_done, mem_rdata,
        input  wr_ack, rd_ack, rd_valid, rd_data,
               mem_en, mem_we, mem_addr, mem_wdata, front_bank, swap
    );

endinterface

// File: rtl/fb_bank_arbiter_rr_arb2.sv
// Two-requester round-robin (reader/writer) with an inhibit that blocks all
// grants; on a tie the side not granted last wins.
module rr_arb2 import fb_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic req_rd_i,
    input  logic req_wr_i,
    input  logic inhibit_i,
    output logic gnt_rd_o,
    output logic gnt_wr_o
);

    grant_e last_grant_q;
    grant_e last_grant_d;
    logic   gnt_rd_s;
    logic   gnt_wr_s;

    // Grant selection and last-grant bookkeeping
    always_comb begin
        if (inhibit_i) begin
            gnt_rd_s = 1'b0;
            gnt_wr_s = 1'b0;
        end else if (req_rd_i && req_wr_i) begin
            gnt_rd_s = (last_grant_q == GNT_WR);
            gnt_wr_s = (last_grant_q == GNT_RD);
        end else begin
            gnt_rd_s = req_rd_i;
            gnt_wr_s = req_wr_i;
        end

        if (gnt_rd_s) begin
            last_grant_d = GNT_RD;
        end else if (gnt_wr_s) begin
            last_grant_d = GNT_WR;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant register; resets to writer so the reader wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_WR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt_rd_o = gnt_rd_s;
    assign gnt_wr_o = gnt_wr_s;

endmodule

// File: rtl/fb_bank_arbiter.sv
// Double-buffered frame-buffer arbiter: camera writes the back bank, the OLED
// reader fetches the front bank, banks swap once both frames are complete.
module fb_bank_arbiter import fb_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    fb_bank_arbiter_if.slave   bus
);

    swap_state_e state_q;
    logic        front_bank_q;
    logic        swap_q;
    logic        rd_valid_q;
    logic        rd_hit_q;

    logic gnt_rd_s;
    logic gnt_wr_s;
    logic inhibit_s;
    logic wr_ok_s;
    logic rd_ok_s;
    logic wr_frame_s;

    // Grants are blocked during reset so acks and mem_en stay low
    assign inhibit_s  = (state_q == S_SWAP) || !rst_n;
    assign wr_frame_s = bus.wr_frame_done && !bus.freeze;
    assign wr_ok_s    = addr_in_range(bus.wr_addr);
    assign rd_ok_s    = addr_in_range(bus.rd_addr);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_rd_i  (bus.rd_req),
        .req_wr_i  (bus.wr_req && !bus.freeze),
        .inhibit_i (inhibit_s),
        .gnt_rd_o  (gnt_rd_s),
        .gnt_wr_o  (gnt_wr_s)
    );

    // Bank-swap FSM with registered swap pulse and front-bank select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            front_bank_q <= 1'b0;
            swap_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    swap_q <= wr_frame_s && bus.rd_frame_done;
                    if (wr_frame_s && bus.rd_frame_done) begin
                        state_q <= S_SWAP;
                    end else if (wr_frame_s) begin
                        state_q <= S_WR_DONE;
                    end else if (bus.rd_frame_done) begin
                        state_q <= S_RD_DONE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                // Capture frame is already complete here, so freeze no longer matters
                S_WR_DONE: begin
                    swap_q  <= bus.rd_frame_done;
                    state_q <= bus.rd_frame_done ? S_SWAP : S_WR_DONE;
                end
                S_RD_DONE: begin
                    swap_q  <= wr_frame_s;
                    state_q <= wr_frame_s ? S_SWAP : S_RD_DONE;
                end
                S_SWAP: begin
                    swap_q       <= 1'b0;
                    front_bank_q <= ~front_bank_q;
                    state_q      <= S_IDLE;
                end
                default: begin
                    swap_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read-return tracking; out-of-range reads complete with zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_valid_q <= gnt_rd_s;
            rd_hit_q   <= gnt_rd_s && rd_ok_s;
        end
    end

    // BRAM port steering: writer targets the back bank, reader the front bank
    always_comb begin
        if (gnt_wr_s) begin
            bus.mem_en    = wr_ok_s;
            bus.mem_we    = wr_ok_s;
            bus.mem_addr  = {~front_bank_q, bus.wr_addr};
            bus.mem_wdata = bus.wr_data;
        end else if (gnt_rd_s) begin
            bus.mem_en    = rd_ok_s;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = {front_bank_q, bus.rd_addr};
            bus.mem_wdata = {c_nb_buf{1'b0}};
        end else begin
            bus.mem_en    = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = {(c_nb_img_pxls + 1){1'b0}};
            bus.mem_wdata = {c_nb_buf{1'b0}};
        end
    end

    assign bus.wr_ack     = gnt_wr_s;
    assign bus.rd_ack     = gnt_rd_s;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_hit_q ? bus.mem_rdata : {c_nb_buf{1'b0}};
    assign bus.front_bank = front_bank_q;
    assign bus.swap       = swap_q;

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Bench for fb_bank_arbiter: BRAM model, per-bank picture reference model and
// directed plus randomized scenarios.
module tb_fb_bank_arbiter;
    import fb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    fb_bank_arbiter_if bus ();
    fb_bank_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    function automatic logic [11:0] init_val(input logic [13:0] i);
        if (i == 14'd5) return 12'hABC;
        return i[11:0] ^ {i[13:12], 10'h2A5};
    endfunction

    // BRAM model: one-cycle synchronous read, preloaded once
    logic [11:0] bram [0:16383];
    logic bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < 16384; i++) bram[i] <= init_val(14'(i));
            bram_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= bram[bus.mem_addr];
        end
    end

    // Reference model: picture per bank, frame-done flags, round-robin winner
    logic [11:0] pic [0:1][0:c_img_pxls-1];
    logic pic_init = 1'b0;
    logic m_front, m_wdone, m_rdone, m_swap, m_last_wr, m_rv;
    logic [11:0] m_rd;
    int who;
    logic e_en, e_we, nx_w, nx_r;
    logic [13:0] e_addr;
    logic [44:0] exp_v, obs_v;

    always_comb begin
        who = 0;
        if (rst_n && !m_swap) begin
            if (bus.rd_req && bus.wr_req && !bus.freeze) who = m_last_wr ? 1 : 2;
            else if (bus.rd_req) who = 1;
            else if (bus.wr_req && !bus.freeze) who = 2;
        end
        e_en = 1'b0; e_we = 1'b0; e_addr = 14'd0;
        if (who == 1) begin
            e_en = (bus.rd_addr < c_img_pxls_a);
            e_addr = {m_front, bus.rd_addr};
        end
        if (who == 2) begin
            e_en = (bus.wr_addr < c_img_pxls_a);
            e_we = e_en;
            e_addr = {!m_front, bus.wr_addr};
        end
        nx_w = m_wdone || (bus.wr_frame_done && !bus.freeze);
        nx_r = m_rdone || bus.rd_frame_done;
        exp_v = {who == 2, who == 1, e_en, e_we, e_en ? e_addr : 14'd0,
                 e_we ? bus.wr_data : 12'd0, m_rv, m_rv ? m_rd : 12'd0, m_swap, m_front};
        obs_v = {bus.wr_ack, bus.rd_ack, bus.mem_en, bus.mem_we, e_en ? bus.mem_addr : 14'd0,
                 e_we ? bus.mem_wdata : 12'd0, bus.rd_valid, m_rv ? bus.rd_data : 12'd0,
                 bus.swap, bus.front_bank};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!pic_init) begin
                for (int b = 0; b < 2; b++)
                    for (int a = 0; a < c_img_pxls; a++)
                        pic[b][a] <= init_val({1'(b), 13'(a)});
                pic_init <= 1'b1;
            end
            m_front <= 1'b0; m_wdone <= 1'b0; m_rdone <= 1'b0; m_swap <= 1'b0;
            m_last_wr <= 1'b1; m_rv <= 1'b0; m_rd <= 12'd0;
        end else begin
            m_rv <= (who == 1);
            m_rd <= (who == 1 && e_en) ? pic[m_front][bus.rd_addr] : 12'd0;
            if (who == 2 && e_en) pic[!m_front][bus.wr_addr] <= bus.wr_data;
            if (who != 0) m_last_wr <= (who == 2);
            if (m_swap) begin
                m_front <= !m_front;
                m_swap  <= 1'b0;
            end else if (nx_w && nx_r) begin
                m_swap <= 1'b1; m_wdone <= 1'b0; m_rdone <= 1'b0;
            end else begin
                m_wdone <= nx_w; m_rdone <= nx_r;
            end
        end
    end

    task automatic drive(input logic wr, input logic [12:0] wa, input logic [11:0] wd,
                         input logic rd, input logic [12:0] ra,
                         input logic wfd, input logic rfd, input logic frz);
        bus.wr_req = wr; bus.wr_addr = wa; bus.wr_data = wd;
        bus.rd_req = rd; bus.rd_addr = ra;
        bus.wr_frame_done = wfd; bus.rd_frame_done = rfd; bus.freeze = frz;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [12:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 13'($urandom_range(4795, 4805));
        return 13'($urandom_range(0, 31));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 13'd10, 12'h123, 1'b1, 13'd10, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        #1;
        checks++;
        if ({bus.wr_ack, bus.rd_ack, bus.mem_en, bus.mem_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_grants: got %b want 0000", {bus.wr_ack, bus.rd_ack, bus.mem_en, bus.mem_we});
        end
        checks++;
        if ({bus.rd_valid, bus.rd_data, bus.front_bank, bus.swap} !== 15'd0) begin
            errors++; $display("FAIL reset_state: got %h want 0", {bus.rd_valid, bus.rd_data, bus.front_bank, bus.swap});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_read();
        drive(1'b0, 13'd0, 12'd0, 1'b1, 13'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.rd_ack, bus.wr_ack, bus.mem_en, bus.mem_we} !== 4'b1010) begin
            errors++; $display("FAIL first_read_ack: got %b want 1010", {bus.rd_ack, bus.wr_ack, bus.mem_en, bus.mem_we});
        end
        checks++;
        if (bus.mem_addr !== 14'h0005) begin
            errors++; $display("FAIL first_read_addr: got %h want 0005", bus.mem_addr);
        end
        tick();
        drive(1'b0, 13'd0, 12'd0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 12'hABC}) begin
            errors++; $display("FAIL first_read_data: got %b/%h want 1/abc", bus.rd_valid, bus.rd_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 13'(100 + k), 12'(k), 1'b1, 13'(200 + k), 1'b0, 1'b0, 1'b0);
            checks++;
            if ({bus.wr_ack, bus.rd_ack} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_order%0d: got %b want %b", k, {bus.wr_ack, bus.rd_ack}, (k % 2 == 1) ? 2'b10 : 2'b01);
            end
            checks++;
            if ({bus.mem_addr[13], bus.mem_we} !== ((k % 2 == 1) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL rr_bank%0d: got %b want %b", k, {bus.mem_addr[13], bus.mem_we}, (k % 2 == 1) ? 2'b11 : 2'b00);
            end
            tick();
        end
    endtask

    task automatic test_swap();
        for (int i = 0; i < 12; i++) begin
            if (i == 11)
                drive(1'b1, 13'd40, 12'h040, 1'b1, 13'd41, 1'b0, 1'b0, 1'b0);
            else
                drive(1'($urandom_range(0, 1)), 13'($urandom_range(0, 31)), 12'($urandom),
                      1'($urandom_range(0, 1)), 13'($urandom_range(0, 31)), i == 0, i == 10, 1'b0);
            if (i == 11) begin
                checks++;
                if ({bus.swap, bus.wr_ack, bus.rd_ack, bus.mem_en} !== 4'b1000) begin
                    errors++; $display("FAIL swap_cycle: got %b want 1000", {bus.swap, bus.wr_ack, bus.rd_ack, bus.mem_en});
                end
            end
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL swap_seq%0d: got %h want %h", i, obs_v, exp_v);
            end
            tick();
        end
        drive(1'b1, 13'd7, 12'h777, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.front_bank, bus.swap, bus.wr_ack, bus.mem_addr[13]} !== 4'b1010) begin
            errors++; $display("FAIL swap_wr_bank: got %b want 1010", {bus.front_bank, bus.swap, bus.wr_ack, bus.mem_addr[13]});
        end
        tick();
        drive(1'b0, 13'd0, 12'd0, 1'b1, 13'd7, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.rd_ack, bus.mem_addr[13]} !== 2'b11) begin
            errors++; $display("FAIL swap_rd_bank: got %b want 11", {bus.rd_ack, bus.mem_addr[13]});
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 13'd0, 12'd0, 1'b1, 13'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL swap_readback%0d: got %h want %h", i, obs_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 13'd50, 12'h5A5, i >= 4, 13'(i), i == 0, i == 4, 1'b1);
            checks++;
            if ({bus.wr_ack, bus.swap, bus.rd_ack} !== {2'b00, i >= 4}) begin
                errors++; $display("FAIL freeze%0d: got %b want %b", i, {bus.wr_ack, bus.swap, bus.rd_ack}, {2'b00, i >= 4});
            end
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL freeze_model%0d: got %h want %h", i, obs_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 13'd4800, 12'hFFF, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.wr_ack, bus.mem_en, bus.mem_we} !== 3'b100) begin
            errors++; $display("FAIL oor_write: got %b want 100", {bus.wr_ack, bus.mem_en, bus.mem_we});
        end
        tick();
        drive(1'b0, 13'd0, 12'd0, 1'b1, 13'd4800, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.rd_ack, bus.mem_en} !== 2'b10) begin
            errors++; $display("FAIL oor_read: got %b want 10", {bus.rd_ack, bus.mem_en});
        end
        tick();
        drive(1'b0, 13'd0, 12'd0, 1'b1, 13'd4799, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.rd_valid, bus.rd_data, bus.mem_en} !== {1'b1, 12'h000, 1'b1}) begin
            errors++; $display("FAIL oor_rdata: got %b/%h/%b want 1/000/1", bus.rd_valid, bus.rd_data, bus.mem_en);
        end
        tick();
        drive(1'b0, 13'd0, 12'd0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL edge_read: got %h want %h", obs_v, exp_v);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), rnd_addr(), 12'($urandom),
                  1'($urandom_range(0, 1)), rnd_addr(),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random%0d: got %h want %h", i, obs_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 2; r++) begin
            if (!m_front) begin
                for (int i = 0; i < 3; i++) begin
                    drive(1'b0, 13'd0, 12'd0, 1'b0, 13'd0, i < 2, i < 2, 1'b0);
                    tick();
                end
            end
        end
        drive(1'b0, 13'd0, 12'd0, 1'b1, 13'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL pre_reset_read: got %h want %h", obs_v, exp_v);
        end
        tick();
        rst_n = 1'b0;
        drive(1'b0, 13'd0, 12'd0, 1'b1, 13'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.rd_valid, bus.front_bank, bus.swap, bus.rd_ack} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset: got %b want 0000", {bus.rd_valid, bus.front_bank, bus.swap, bus.rd_ack});
        end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 13'd1, 12'h111, 1'b1, 13'd2, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.rd_ack, bus.wr_ack, bus.rd_valid} !== 3'b100) begin
            errors++; $display("FAIL post_reset_tie: got %b want 100", {bus.rd_ack, bus.wr_ack, bus.rd_valid});
        end
        tick();
    endtask

    initial begin
        drive(1'b0, 13'd0, 12'd0, 1'b0, 13'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_first_read();
        test_round_robin();
        test_swap();
        test_freeze();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
